// File: rtl/spart_mmio.sv
// rtl/spart_mmio.sv - memory-mapped 8N1 UART with TX/RX FIFOs and programmable baud divisor
module spart_mmio #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DEFAULT_DB = 16'd434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        wr,
    input  logic [1:0]  addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        TX,
    input  logic        RX
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [3:0] DEPTH4 = 4'(FIFO_DEPTH);

    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    logic [15:0]   db_q;
    logic [7:0]    txf_mem_q [FIFO_DEPTH];
    logic [7:0]    rxf_mem_q [FIFO_DEPTH];
    logic [PW-1:0] txf_wp_q, txf_rp_q, rxf_wp_q, rxf_rp_q;
    logic [3:0]    txf_cnt_q, rxf_cnt_q;

    tx_state_e     tx_state_q, tx_state_d;
    logic [9:0]    tx_shift_q, tx_shift_d;
    logic [15:0]   tx_baud_q, tx_baud_d;
    logic [3:0]    tx_bit_q, tx_bit_d;

    logic [1:0]    rx_sync_q;
    rx_state_e     rx_state_q, rx_state_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [15:0]   rx_baud_q, rx_baud_d;
    logic [2:0]    rx_bit_q, rx_bit_d;

    logic bus_wr, bus_rd, tx_push, tx_pop, rx_push, rx_pop, rx_done, tx_tick, rx_tick, rx_s;
    logic unused_hi;

    assign unused_hi = ^data_in[15:8];
    assign bus_wr    = cs & wr;
    assign bus_rd    = cs & ~wr;
    assign rx_s      = rx_sync_q[1];

    // Pushing into a full FIFO is allowed when the same cycle also pops it.
    assign tx_push = bus_wr && addr == 2'd0 && (txf_cnt_q != DEPTH4 || tx_pop);
    assign rx_pop  = bus_rd && addr == 2'd0 && rxf_cnt_q != 4'd0;
    assign rx_push = rx_done && (rxf_cnt_q != DEPTH4 || rx_pop);

    // 17-bit compares so DB = 0 still ticks every clock instead of stalling.
    assign tx_tick = ({1'b0, tx_baud_q} + 17'd1) >= {1'b0, db_q};
    assign rx_tick = (rx_state_q == RX_START)
                   ? (({1'b0, rx_baud_q} + 17'd1) >= {2'b00, db_q[15:1]})
                   : (({1'b0, rx_baud_q} + 17'd1) >= {1'b0, db_q});

    always_comb begin
        data_out = 16'h0000;
        if (cs) begin
            case (addr)
                2'd0: data_out = {8'h00, (rxf_cnt_q != 4'd0) ? rxf_mem_q[rxf_rp_q] : 8'h00};
                2'd1: data_out = {8'h00, DEPTH4 - txf_cnt_q, rxf_cnt_q};
                2'd2: data_out = {8'h00, db_q[7:0]};
                default: data_out = {8'h00, db_q[15:8]};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) txf_mem_q[txf_wp_q] <= data_in[7:0];
        if (rx_push) rxf_mem_q[rxf_wp_q] <= rx_shift_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q       <= DEFAULT_DB;
            txf_wp_q   <= '0;
            txf_rp_q   <= '0;
            txf_cnt_q  <= '0;
            rxf_wp_q   <= '0;
            rxf_rp_q   <= '0;
            rxf_cnt_q  <= '0;
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '1;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            rx_sync_q  <= 2'b11;
            rx_state_q <= RX_IDLE;
            rx_shift_q <= '0;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
        end else begin
            if (bus_wr && addr == 2'd2) db_q[7:0]  <= data_in[7:0];
            if (bus_wr && addr == 2'd3) db_q[15:8] <= data_in[7:0];
            if (tx_push) txf_wp_q <= txf_wp_q + PW'(1);
            if (tx_pop)  txf_rp_q <= txf_rp_q + PW'(1);
            txf_cnt_q  <= txf_cnt_q + {3'b000, tx_push} - {3'b000, tx_pop};
            if (rx_push) rxf_wp_q <= rxf_wp_q + PW'(1);
            if (rx_pop)  rxf_rp_q <= rxf_rp_q + PW'(1);
            rxf_cnt_q  <= rxf_cnt_q + {3'b000, rx_push} - {3'b000, rx_pop};
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            rx_sync_q  <= {rx_sync_q[0], RX};
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_baud_q  <= rx_baud_d;
            rx_bit_q   <= rx_bit_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (txf_cnt_q != 4'd0) begin
                    tx_state_d = TX_SHIFT;
                    tx_shift_d = {1'b1, txf_mem_q[txf_rp_q], 1'b0};
                    tx_baud_d  = '0;
                    tx_bit_d   = '0;
                end
            end
            default: begin
                if (tx_tick) begin
                    tx_baud_d  = '0;
                    tx_shift_d = {1'b1, tx_shift_q[9:1]};
                    tx_bit_d   = tx_bit_q + 4'd1;
                    if (tx_bit_q == 4'd9) tx_state_d = TX_IDLE;
                end else begin
                    tx_baud_d = tx_baud_q + 16'd1;
                end
            end
        endcase
    end

    always_comb begin
        tx_pop = (tx_state_q == TX_IDLE) && (txf_cnt_q != 4'd0);
        TX     = (tx_state_q == TX_SHIFT) ? tx_shift_q[0] : 1'b1;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_baud_d  = rx_baud_q;
        rx_bit_d   = rx_bit_q;
        case (rx_state_q)
            RX_IDLE: begin
                rx_baud_d = '0;
                if (!rx_s) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_tick) begin
                    rx_baud_d  = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_baud_d = rx_baud_q + 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_baud_d  = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    rx_baud_d = rx_baud_q + 16'd1;
                end
            end
            default: begin
                if (rx_tick) begin
                    rx_baud_d  = '0;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_baud_d = rx_baud_q + 16'd1;
                end
            end
        endcase
    end

    always_comb begin
        rx_done = (rx_state_q == RX_STOP) && rx_tick && rx_s;
    end
endmodule
